// File: rtl/key_sweep_pkg.sv
// key_sweep_pkg: shared types and constants for the key sweep sequencer.
//   KEY_W    - key / operand width
//   SUM_W    - adder result width including carry-out
//   KEY_LAST - final key value of a sweep
//   state_e  - sequencer FSM states
package key_sweep_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned SUM_W = KEY_W + 1;
  localparam logic [KEY_W-1:0] KEY_LAST = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/locked_adder_dp.sv
// locked_adder_dp: combinational key-locked adder.
//   sum = {1'b0, a ^ key} + b + cin, built as an explicit ripple-carry chain.
// Ports:
//   a, key, b - KEY_W-bit operands and key
//   cin       - carry-in
//   sum       - SUM_W-bit result, MSB is the carry-out
module locked_adder_dp
  import key_sweep_pkg::*;
(
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] b,
  input  logic             cin,
  output logic [SUM_W-1:0] sum
);

  logic [KEY_W-1:0] a_locked;
  logic [KEY_W:0]   carry;

  assign a_locked = a ^ key;
  assign carry[0] = cin;

  for (genvar i = 0; i < int'(KEY_W); i++) begin : g_rca
    assign sum[i]     = a_locked[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a_locked[i] & b[i]) | (carry[i] & (a_locked[i] ^ b[i]));
  end

  assign sum[KEY_W] = carry[KEY_W];

endmodule

// File: rtl/key_sweep_ctrl.sv
// key_sweep_ctrl: sweeps all 256 keys through the locked adder for one latched test vector,
// compares each sum with a masked golden value and streams matching keys out over
// valid/ready. Reports the number of matches and the lowest matching key.
// Optional feature macro: KEY_SWEEP_EARLY_EXIT_EN - stop the sweep after the first accepted hit.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin a sweep (honoured only when idle)
//   a, b, cin           - test vector, latched on accepted start
//   golden, golden_mask - oracle sum and compare mask, latched on accepted start
//   busy, done          - sweep/drain in progress, one-cycle completion pulse
//   match_valid/ready   - output slot handshake, match_key carries the key
//   match_cnt           - matches in the current/last sweep (0..256)
//   first_key           - lowest matching key, meaningful when match_cnt != 0
module key_sweep_ctrl
  import key_sweep_pkg::*;
#(
  parameter int unsigned KEY_W = 8,
  parameter int unsigned SUM_W = KEY_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  input  logic             cin,
  input  logic [SUM_W-1:0] golden,
  input  logic [SUM_W-1:0] golden_mask,
  output logic             busy,
  output logic             done,
  output logic             match_valid,
  input  logic             match_ready,
  output logic [KEY_W-1:0] match_key,
  output logic [SUM_W-1:0] match_cnt,
  output logic [KEY_W-1:0] first_key
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic [KEY_W-1:0] a_q, a_d;
  logic [KEY_W-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [SUM_W-1:0] golden_q, golden_d;
  logic [SUM_W-1:0] mask_q, mask_d;
  logic             mv_q, mv_d;
  logic [KEY_W-1:0] mk_q, mk_d;
  logic [SUM_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] first_q, first_d;
`ifdef KEY_SWEEP_EARLY_EXIT_EN
  logic             found_q, found_d;
`endif

  logic [SUM_W-1:0] sum;
  logic             hit;
  logic             slot_free;
  logic             advance;

  locked_adder_dp u_dp (
    .a   (a_q),
    .key (k_q),
    .b   (b_q),
    .cin (cin_q),
    .sum (sum)
  );

  assign hit       = ((sum ^ golden_q) & mask_q) == '0;
  // Slot can take a new key if empty or being emptied this very cycle.
  assign slot_free = !mv_q || match_ready;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    golden_d = golden_q;
    mask_d   = mask_q;
    mv_d     = mv_q && !match_ready;
    mk_d     = mk_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    advance  = 1'b0;
`ifdef KEY_SWEEP_EARLY_EXIT_EN
    found_d  = found_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          cin_d    = cin;
          golden_d = golden;
          mask_d   = golden_mask;
          k_d      = '0;
          cnt_d    = '0;
          first_d  = '0;
`ifdef KEY_SWEEP_EARLY_EXIT_EN
          found_d  = 1'b0;
`endif
          state_d  = StSweep;
        end
      end

      StSweep: begin
`ifdef KEY_SWEEP_EARLY_EXIT_EN
        if (found_q) begin
          state_d = StDrain;
        end else
`endif
        if (hit) begin
          if (slot_free) begin
            mv_d    = 1'b1;
            mk_d    = k_q;
            cnt_d   = cnt_q + 1'b1;
            advance = 1'b1;
            if (cnt_q == '0) first_d = k_q;
`ifdef KEY_SWEEP_EARLY_EXIT_EN
            found_d = 1'b1;
`endif
          end
          // Otherwise stall: key, count and slot all hold.
        end else begin
          advance = 1'b1;
        end

        if (advance) begin
          k_d = k_q + 1'b1;
          if (k_q == KEY_LAST) state_d = StDrain;
        end
      end

      StDrain: begin
        if (slot_free) state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      golden_q <= '0;
      mask_q   <= '0;
      mv_q     <= 1'b0;
      mk_q     <= '0;
      cnt_q    <= '0;
      first_q  <= '0;
`ifdef KEY_SWEEP_EARLY_EXIT_EN
      found_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      golden_q <= golden_d;
      mask_q   <= mask_d;
      mv_q     <= mv_d;
      mk_q     <= mk_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
`ifdef KEY_SWEEP_EARLY_EXIT_EN
      found_q  <= found_d;
`endif
    end
  end

  assign busy        = (state_q == StSweep) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign match_valid = mv_q;
  assign match_key   = mk_q;
  assign match_cnt   = cnt_q;
  assign first_key   = first_q;

endmodule

// File: doc/key_sweep_ctrl.md
# key_sweep_ctrl

Sequencer that drives one key-locked 8-bit adder datapath (operand A XORed with an 8-bit key, then added to B with carry-in, 9-bit sum) through all 256 key values for one fixed test vector. Each candidate sum is compared against a golden oracle sum under a bit mask. Matching keys are streamed out over a valid/ready handshake, and a match count is reported. It sits between the test-vector source and the key-recovery logic, and owns the shared locked adder for the duration of a sweep.

## Interface
Parameters:
- KEY_W, 8, key and operand width; fixed at 8 for this release.
- SUM_W, KEY_W+1, adder result width including carry-out.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless the FSM is in IDLE.
- a  in  8  operand A, latched on an accepted start.
- b  in  8  operand B, latched on an accepted start.
- cin  in  1  carry-in, latched on an accepted start.
- golden  in  9  oracle sum, latched on an accepted start.
- golden_mask  in  9  bits compared when set, latched on an accepted start. A mask of 0 makes every key match.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse when the sweep completes.
- match_valid  out  1  match_key holds an unconsumed matching key.
- match_ready  in  1  consumer accepts match_key when match_valid && match_ready.
- match_key  out  8  matching key value.
- match_cnt  out  9  number of matches in the current/last sweep, range 0..256.
- first_key  out  8  lowest matching key; valid only when match_cnt != 0.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - On start, latch a, b, cin, golden and golden_mask.
  - Clear k, match_cnt and first_key.
  - Go to SWEEP.
- SWEEP, each cycle:
  - Datapath computes sum = ({1'b0, a^k}) + b + cin, 9 bits.
  - hit = ((sum ^ golden) & golden_mask) == 0.
- Output slot:
  - One register: match_valid plus match_key.
  - The slot is free when !match_valid, or when match_valid && match_ready in the same cycle.
- Hit handling:
  - hit && slot free: load match_key=k, set match_valid, increment match_cnt, advance k.
  - If this is the first hit, also set first_key=k.
  - hit && slot not free: stall. k, match_cnt and the slot are held.
  - No hit: advance k. The slot clears on acceptance.
- Sweep end: k wraps internally; the FSM leaves SWEEP after k=255 has been processed (not stalled), then enters DRAIN.
- DRAIN: wait until match_valid is low, or is accepted this cycle, then go to DONE.
- DONE: assert done for exactly one cycle, then return to IDLE. match_cnt and first_key hold until the next accepted start.
- A start arriving while busy or in DONE is dropped with no side effect.
- match_cnt is 9 bits so a count of 256 (mask 0) does not wrap.

## Timing
- Reset values: busy=0, done=0, match_valid=0, match_key=0, match_cnt=0, first_key=0, FSM=IDLE, k=0.
- Reset asserted mid-sweep aborts the sweep on that edge. Any pending match is discarded, no done pulse is issued, and all outputs return to their reset values.
- start at edge N → busy=1 from N+1. Key 0 is evaluated in cycle N+1.
- With no stalls: last key evaluated at N+256, DRAIN at N+257, done=1 at N+258 (if the slot is empty), IDLE at N+259.
- Each stall cycle adds exactly one cycle to the total.
- The datapath is combinational within one cycle. A hit is visible on match_valid the cycle after its key is evaluated.
- match_key is stable while match_valid && !match_ready.

## Configuration
- KEY_SWEEP_EARLY_EXIT_EN defined:
  - The first accepted hit ends SWEEP and goes straight to DRAIN; no further keys are evaluated.
  - match_cnt is at most 1.
  - Without stalls, done arrives 3 cycles after the hit key's evaluation cycle.
- KEY_SWEEP_EARLY_EXIT_EN undefined: a full 256-key sweep always runs.

## Structure
- Package key_sweep_pkg holds:
  - State enum: IDLE, SWEEP, DRAIN, DONE.
  - Constants: KEY_W=8, SUM_W=9, KEY_LAST=8'hFF.
- One sub-module, locked_adder_dp: purely combinational XOR-key stage plus 8-bit ripple-carry adder, producing the 9-bit sum. It is instantiated once.
- The FSM, key counter, output slot and counters live in key_sweep_ctrl.

## Test plan
- a=174, b=147, cin=0, golden=151, mask=9'h1FF, ready=1 → a single match with match_key=8'hAA, match_cnt=1, first_key=8'hAA, done at start+258.
- a=8'h0F, b=8'hFF, cin=1, golden=511, mask=9'h1FF → match_key=8'hF0, match_cnt=1.
- a=0, b=0, cin=0, golden=9'h100, mask=9'h1FF → no match_valid ever, match_cnt=0, done at start+258.
- mask=0, ready toggling 1,0,1,0 → keys 0..255 delivered in order with none lost or duplicated, match_cnt=256, first_key=0. Total cycles equal 258 plus the number of stall cycles.
- rst held high for 1 cycle at start+100 during a mask=0 sweep → all outputs at reset values the next cycle, no done pulse. A fresh start then completes normally.
- With KEY_SWEEP_EARLY_EXIT_EN and mask=0, ready=1 → one match (key 0), match_cnt=1, done at start+4.
